mini_src_control_unit: RTL and testbench

- Hardwired Moore control unit that sequences the Mini SRC bus datapath through fetch (T0–T2) and per-opcode execute steps (T3–T7).
- Drives every datapath enable, bus-source, ALU-select and select/encode signal.
- Reads the latched IR and branch condition flag; stops on HALT or an external Stop.

---
 rtl/mini_src_control_unit_pkg.sv | 103 ++++++++++
 rtl/mini_src_control_unit_if.sv | 42 ++++
 rtl/mini_src_control_unit_op_decode.sv | 47 ++++
 rtl/mini_src_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mini_src_control_unit_pkg.sv
// Shared constants and types for the Mini SRC hardwired control unit.
// The optional I/O port instructions are enabled with the CU_IO_EN macro.
package mini_src_pkg;

    localparam int OPC_W = 5;
    localparam int ALU_N = 13;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10101;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // Bit positions inside the one-hot AluSel vector.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_OR   = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } step_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_BR,
        CLS_JR,
        CLS_MFLO,
        CLS_MFHI,
        CLS_HALT,
        CLS_IN,
        CLS_OUT
    } op_class_t;

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout;
        logic PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, CONin, Rin;
        logic Gra, Grb, Grc;
        logic IncPC, Read, RAMWrite;
`ifdef CU_IO_EN
        logic InPortout, OutPortin;
`endif
        logic [ALU_N-1:0] AluSel;
    } ctrl_t;

    // Final execute step of each instruction class; never earlier than T3.
    function automatic step_t last_step(input op_class_t opClass);
        case (opClass)
            CLS_ALU_R, CLS_ALU_I, CLS_LDI: last_step = S_T5;
            CLS_LD:                        last_step = S_T7;
            CLS_ST, CLS_MULDIV, CLS_BR:    last_step = S_T6;
            CLS_UNARY:                     last_step = S_T4;
            default:                       last_step = S_T3;
        endcase
    endfunction

endpackage

// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and its datapath (slave).
// InPortout/OutPortin exist only when CU_IO_EN is defined.
interface mini_src_control_unit_if;

    logic [31:0] IR;
    logic        CON;
    logic        Stop;

    logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, CONin, Rin;
    logic Gra, Grb, Grc;
    logic IncPC, Read, RAMWrite;
`ifdef CU_IO_EN
    logic InPortout, OutPortin;
`endif
    logic [mini_src_pkg::ALU_N-1:0] AluSel;
    logic       Run;
    logic [2:0] Tstep;

    modport master (
        input  IR, CON, Stop,
        output PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout,
        output PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, CONin, Rin,
        output Gra, Grb, Grc, IncPC, Read, RAMWrite,
`ifdef CU_IO_EN
        output InPortout, OutPortin,
`endif
        output AluSel, Run, Tstep
    );

    modport slave (
        output IR, CON, Stop,
        input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout,
        input  PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, CONin, Rin,
        input  Gra, Grb, Grc, IncPC, Read, RAMWrite,
`ifdef CU_IO_EN
        input  InPortout, OutPortin,
`endif
        input  AluSel, Run, Tstep
    );

endinterface

// File: rtl/mini_src_control_unit_op_decode.sv
// Combinational opcode decoder: instruction class plus ALU operation index.
// Opcodes in/out decode as nop unless CU_IO_EN is defined.
module mini_src_op_decode
    import mini_src_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output op_class_t        o_opClass,
    output logic [3:0]       o_aluIdx
);

    always_comb begin
        o_opClass = CLS_NOP;
        o_aluIdx  = ALU_ADD;
        case (i_opcode)
            OP_LD:   o_opClass = CLS_LD;
            OP_LDI:  o_opClass = CLS_LDI;
            OP_ST:   o_opClass = CLS_ST;
            OP_ADD:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_ADD;  end
            OP_SUB:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_SUB;  end
            OP_AND:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_AND;  end
            OP_OR:   begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_OR;   end
            OP_ROR:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_ROR;  end
            OP_ROL:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_ROL;  end
            OP_SHR:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_SHR;  end
            OP_SHRA: begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_SHRA; end
            OP_SHL:  begin o_opClass = CLS_ALU_R;  o_aluIdx = ALU_SHL;  end
            OP_ADDI: begin o_opClass = CLS_ALU_I;  o_aluIdx = ALU_ADD;  end
            OP_ANDI: begin o_opClass = CLS_ALU_I;  o_aluIdx = ALU_AND;  end
            OP_ORI:  begin o_opClass = CLS_ALU_I;  o_aluIdx = ALU_OR;   end
            OP_DIV:  begin o_opClass = CLS_MULDIV; o_aluIdx = ALU_DIV;  end
            OP_MUL:  begin o_opClass = CLS_MULDIV; o_aluIdx = ALU_MUL;  end
            OP_NEG:  begin o_opClass = CLS_UNARY;  o_aluIdx = ALU_NEG;  end
            OP_NOT:  begin o_opClass = CLS_UNARY;  o_aluIdx = ALU_NOT;  end
            OP_BR:   o_opClass = CLS_BR;
            OP_JR:   o_opClass = CLS_JR;
`ifdef CU_IO_EN
            OP_IN:   o_opClass = CLS_IN;
            OP_OUT:  o_opClass = CLS_OUT;
`endif
            OP_MFLO: o_opClass = CLS_MFLO;
            OP_MFHI: o_opClass = CLS_MFHI;
            OP_HALT: o_opClass = CLS_HALT;
            default: o_opClass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit sequencing the Mini SRC datapath through fetch and execute.
// Defining CU_IO_EN adds the in/out instructions and their InPortout/OutPortin strobes.
module mini_src_control_unit
    import mini_src_pkg::*;
(
    input  logic                   i_Clock,
    input  logic                   i_Clear,
    mini_src_control_unit_if.master bus
);

    step_t     r_state;
    step_t     w_nextState;
    step_t     w_lastStep;
    op_class_t w_opClass;
    logic [3:0] w_aluIdx;
    ctrl_t     w_ctrl;
    logic      w_unusedIr;

    assign w_unusedIr = ^bus.IR[31-OPC_W:0];

    mini_src_op_decode u_decode (
        .i_opcode  (bus.IR[31:32-OPC_W]),
        .o_opClass (w_opClass),
        .o_aluIdx  (w_aluIdx)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Clear) begin
            r_state <= S_T0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Stop is only honoured on the final step, so instructions always complete.
    always_comb begin
        w_nextState = r_state;
        w_lastStep  = last_step(w_opClass);
        if (r_state == S_HALT) begin
            w_nextState = S_HALT;
        end else if (r_state == S_T3 && w_opClass == CLS_HALT) begin
            w_nextState = S_HALT;
        end else if (r_state == w_lastStep || r_state == S_T7) begin
            w_nextState = bus.Stop ? S_HALT : S_T0;
        end else begin
            w_nextState = step_t'(r_state + 4'd1);
        end
    end

    always_comb begin
        w_ctrl = '0;
        if (!i_Clear) begin
            case (r_state)
                S_T0: begin
                    w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1;
                    w_ctrl.IncPC = 1'b1; w_ctrl.Zin   = 1'b1;
                end
                S_T1: begin
                    w_ctrl.Zlowout = 1'b1; w_ctrl.PCin  = 1'b1;
                    w_ctrl.Read    = 1'b1; w_ctrl.MDRin = 1'b1;
                end
                S_T2: begin
                    w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
                end
                S_T3: begin
                    case (w_opClass)
                        CLS_ALU_R, CLS_ALU_I: begin
                            w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1;
                        end
                        CLS_LD, CLS_LDI, CLS_ST: begin
                            w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1;
                        end
                        CLS_UNARY: begin
                            w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Zin = 1'b1;
                            w_ctrl.AluSel[w_aluIdx] = 1'b1;
                        end
                        CLS_BR: begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.CONin = 1'b1;
                        end
                        CLS_JR: begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1;
                        end
                        CLS_MFLO: begin
                            w_ctrl.LOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        end
                        CLS_MFHI: begin
                            w_ctrl.HIout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        end
`ifdef CU_IO_EN
                        CLS_IN: begin
                            w_ctrl.InPortout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        end
                        CLS_OUT: begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.OutPortin = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (w_opClass)
                        CLS_ALU_R, CLS_MULDIV: begin
                            w_ctrl.Grc  = (w_opClass == CLS_ALU_R);
                            w_ctrl.Grb  = (w_opClass == CLS_MULDIV);
                            w_ctrl.Rout = 1'b1; w_ctrl.Zin = 1'b1;
                            w_ctrl.AluSel[w_aluIdx] = 1'b1;
                        end
                        CLS_ALU_I: begin
                            w_ctrl.Cout = 1'b1; w_ctrl.Zin = 1'b1;
                            w_ctrl.AluSel[w_aluIdx] = 1'b1;
                        end
                        CLS_LD, CLS_LDI, CLS_ST: begin
                            w_ctrl.Cout = 1'b1; w_ctrl.Zin = 1'b1;
                            w_ctrl.AluSel[ALU_ADD] = 1'b1;
                        end
                        CLS_UNARY: begin
                            w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        end
                        CLS_BR: begin
                            w_ctrl.PCout = 1'b1; w_ctrl.Yin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (w_opClass)
                        CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                            w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                        end
                        CLS_LD, CLS_ST: begin
                            w_ctrl.Zlowout = 1'b1; w_ctrl.MARin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            w_ctrl.Zlowout = 1'b1; w_ctrl.LOin = 1'b1;
                        end
                        CLS_BR: begin
                            w_ctrl.Cout = 1'b1; w_ctrl.Zin = 1'b1;
                            w_ctrl.AluSel[ALU_ADD] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (w_opClass)
                        CLS_LD: begin
                            w_ctrl.Read = 1'b1; w_ctrl.MDRin = 1'b1;
                        end
                        CLS_ST: begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RAMWrite = 1'b1;
                        end
                        CLS_MULDIV: begin
                            w_ctrl.Zhighout = 1'b1; w_ctrl.HIin = 1'b1;
                        end
                        CLS_BR: begin
                            w_ctrl.Zlowout = bus.CON; w_ctrl.PCin = bus.CON;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    if (w_opClass == CLS_LD) begin
                        w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PCout     = w_ctrl.PCout;
    assign bus.Zlowout   = w_ctrl.Zlowout;
    assign bus.Zhighout  = w_ctrl.Zhighout;
    assign bus.MDRout    = w_ctrl.MDRout;
    assign bus.LOout     = w_ctrl.LOout;
    assign bus.HIout     = w_ctrl.HIout;
    assign bus.Cout      = w_ctrl.Cout;
    assign bus.BAout     = w_ctrl.BAout;
    assign bus.Rout      = w_ctrl.Rout;
    assign bus.PCin      = w_ctrl.PCin;
    assign bus.IRin      = w_ctrl.IRin;
    assign bus.Yin       = w_ctrl.Yin;
    assign bus.Zin       = w_ctrl.Zin;
    assign bus.MARin     = w_ctrl.MARin;
    assign bus.MDRin     = w_ctrl.MDRin;
    assign bus.LOin      = w_ctrl.LOin;
    assign bus.HIin      = w_ctrl.HIin;
    assign bus.CONin     = w_ctrl.CONin;
    assign bus.Rin       = w_ctrl.Rin;
    assign bus.Gra       = w_ctrl.Gra;
    assign bus.Grb       = w_ctrl.Grb;
    assign bus.Grc       = w_ctrl.Grc;
    assign bus.IncPC     = w_ctrl.IncPC;
    assign bus.Read      = w_ctrl.Read;
    assign bus.RAMWrite  = w_ctrl.RAMWrite;
`ifdef CU_IO_EN
    assign bus.InPortout = w_ctrl.InPortout;
    assign bus.OutPortin = w_ctrl.OutPortin;
`endif
    assign bus.AluSel    = w_ctrl.AluSel;
    assign bus.Run       = (r_state != S_HALT);
    assign bus.Tstep     = i_Clear ? 3'd0 : r_state[2:0];

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed self-checking bench for mini_src_control_unit (CU_IO_EN aware).
module tb_mini_src_control_unit;

    logic clk = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    mini_src_control_unit_if bus();

    mini_src_control_unit dut (
        .i_Clock (clk),
        .i_Clear (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] M_PCOUT     = 32'h1 << 0;
    localparam logic [31:0] M_ZLOWOUT   = 32'h1 << 1;
    localparam logic [31:0] M_ZHIGHOUT  = 32'h1 << 2;
    localparam logic [31:0] M_MDROUT    = 32'h1 << 3;
    localparam logic [31:0] M_LOOUT     = 32'h1 << 4;
    localparam logic [31:0] M_HIOUT     = 32'h1 << 5;
    localparam logic [31:0] M_COUT      = 32'h1 << 6;
    localparam logic [31:0] M_BAOUT     = 32'h1 << 7;
    localparam logic [31:0] M_ROUT      = 32'h1 << 8;
    localparam logic [31:0] M_PCIN      = 32'h1 << 9;
    localparam logic [31:0] M_IRIN      = 32'h1 << 10;
    localparam logic [31:0] M_YIN       = 32'h1 << 11;
    localparam logic [31:0] M_ZIN       = 32'h1 << 12;
    localparam logic [31:0] M_MARIN     = 32'h1 << 13;
    localparam logic [31:0] M_MDRIN     = 32'h1 << 14;
    localparam logic [31:0] M_LOIN      = 32'h1 << 15;
    localparam logic [31:0] M_HIIN      = 32'h1 << 16;
    localparam logic [31:0] M_CONIN     = 32'h1 << 17;
    localparam logic [31:0] M_RIN       = 32'h1 << 18;
    localparam logic [31:0] M_GRA       = 32'h1 << 19;
    localparam logic [31:0] M_GRB       = 32'h1 << 20;
    localparam logic [31:0] M_GRC       = 32'h1 << 21;
    localparam logic [31:0] M_INCPC     = 32'h1 << 22;
    localparam logic [31:0] M_READ      = 32'h1 << 23;
    localparam logic [31:0] M_RAMWRITE  = 32'h1 << 24;
    localparam logic [31:0] M_INPORTOUT = 32'h1 << 25;
    localparam logic [31:0] M_SOURCES   = 32'h0200_01FF;

    localparam logic [12:0] A_NONE = 13'h0000;
    localparam logic [12:0] A_ADD  = 13'h0001;
    localparam logic [12:0] A_MUL  = 13'h0004;
    localparam logic [12:0] A_OR   = 13'h0400;
    localparam logic [12:0] A_NEG  = 13'h0800;

    logic [31:0] obsWord;
    logic        inPortBit;
    logic        outPortBit;
`ifdef CU_IO_EN
    assign inPortBit  = bus.InPortout;
    assign outPortBit = bus.OutPortin;
`else
    assign inPortBit  = 1'b0;
    assign outPortBit = 1'b0;
`endif
    assign obsWord = {5'b0, outPortBit, inPortBit,
                      bus.RAMWrite, bus.Read, bus.IncPC, bus.Grc, bus.Grb, bus.Gra,
                      bus.Rin, bus.CONin, bus.HIin, bus.LOin, bus.MDRin, bus.MARin,
                      bus.Zin, bus.Yin, bus.IRin, bus.PCin, bus.Rout, bus.BAout,
                      bus.Cout, bus.HIout, bus.LOout, bus.MDRout, bus.Zhighout,
                      bus.Zlowout, bus.PCout};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic con,
                                 input logic stop, input logic clr);
        bus.IR   = ir;
        bus.CON  = con;
        bus.Stop = stop;
        clear    = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expCtrl,
                               input logic [12:0] expAlu, input logic [2:0] expStep,
                               input logic expRun);
        total++;
        assert (obsWord === expCtrl) else begin
            bad++;
            $error("[TB] FAIL %s ctrl got=%h want=%h", tag, obsWord, expCtrl);
        end
        total++;
        assert (bus.AluSel === expAlu) else begin
            bad++;
            $error("[TB] FAIL %s AluSel got=%h want=%h", tag, bus.AluSel, expAlu);
        end
        total++;
        assert (bus.Tstep === expStep) else begin
            bad++;
            $error("[TB] FAIL %s Tstep got=%0d want=%0d", tag, bus.Tstep, expStep);
        end
        total++;
        assert (bus.Run === expRun) else begin
            bad++;
            $error("[TB] FAIL %s Run got=%b want=%b", tag, bus.Run, expRun);
        end
        total++;
        assert ($countones(obsWord & M_SOURCES) <= 1) else begin
            bad++;
            $error("[TB] FAIL %s busSources got=%0d want<=1", tag,
                   $countones(obsWord & M_SOURCES));
        end
    endtask

    task automatic fetch(input logic [31:0] ir);
        checkOutput("fetchT0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, A_NONE, 3'd0, 1'b1);
        tick();
        checkOutput("fetchT1", M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, A_NONE, 3'd1, 1'b1);
        tick();
        applyStimulus(ir, 1'b0, 1'b0, 1'b0);
        checkOutput("fetchT2", M_MDROUT | M_IRIN, A_NONE, 3'd2, 1'b1);
        tick();
    endtask

    initial begin
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("clearHeld", 32'h0, A_NONE, 3'd0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] add R3,R1,R2");
        fetch(32'h1989_0000);
        checkOutput("addT3", M_GRB | M_ROUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("addT4", M_GRC | M_ROUT | M_ZIN, A_ADD, 3'd4, 1'b1); tick();
        checkOutput("addT5", M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 3'd5, 1'b1); tick();

        $display("[TB] ld");
        fetch(32'h0088_0005);
        checkOutput("ldT3", M_GRB | M_BAOUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("ldT4", M_COUT | M_ZIN, A_ADD, 3'd4, 1'b1); tick();
        checkOutput("ldT5", M_ZLOWOUT | M_MARIN, A_NONE, 3'd5, 1'b1); tick();
        checkOutput("ldT6", M_READ | M_MDRIN, A_NONE, 3'd6, 1'b1); tick();
        checkOutput("ldT7", M_MDROUT | M_GRA | M_RIN, A_NONE, 3'd7, 1'b1); tick();

        $display("[TB] st");
        fetch(32'h1000_0000);
        checkOutput("stT3", M_GRB | M_BAOUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("stT4", M_COUT | M_ZIN, A_ADD, 3'd4, 1'b1); tick();
        checkOutput("stT5", M_ZLOWOUT | M_MARIN, A_NONE, 3'd5, 1'b1); tick();
        checkOutput("stT6", M_GRA | M_ROUT | M_RAMWRITE, A_NONE, 3'd6, 1'b1); tick();

        $display("[TB] br not taken");
        fetch(32'h9800_0000);
        checkOutput("brT3", M_GRA | M_ROUT | M_CONIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("brT4", M_PCOUT | M_YIN, A_NONE, 3'd4, 1'b1); tick();
        checkOutput("brT5", M_COUT | M_ZIN, A_ADD, 3'd5, 1'b1); tick();
        checkOutput("brT6con0", 32'h0, A_NONE, 3'd6, 1'b1); tick();

        $display("[TB] br taken");
        fetch(32'h9800_0000);
        tick();
        tick();
        tick();
        applyStimulus(32'h9800_0000, 1'b1, 1'b0, 1'b0);
        checkOutput("brT6con1", M_ZLOWOUT | M_PCIN, A_NONE, 3'd6, 1'b1); tick();
        applyStimulus(32'h9800_0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] neg / ori / jr / mfhi");
        fetch(32'h8800_0000);
        checkOutput("negT3", M_GRB | M_ROUT | M_ZIN, A_NEG, 3'd3, 1'b1); tick();
        checkOutput("negT4", M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 3'd4, 1'b1); tick();
        fetch(32'h7000_0000);
        checkOutput("oriT3", M_GRB | M_ROUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("oriT4", M_COUT | M_ZIN, A_OR, 3'd4, 1'b1); tick();
        checkOutput("oriT5", M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 3'd5, 1'b1); tick();
        fetch(32'hA800_0000);
        checkOutput("jrT3", M_GRA | M_ROUT | M_PCIN, A_NONE, 3'd3, 1'b1); tick();
        fetch(32'hC800_0000);
        checkOutput("mfhiT3", M_HIOUT | M_GRA | M_RIN, A_NONE, 3'd3, 1'b1); tick();

        $display("[TB] undefined opcode and in");
        fetch(32'hA000_0000);
        checkOutput("undefT3", 32'h0, A_NONE, 3'd3, 1'b1); tick();
        fetch(32'hB000_0000);
`ifdef CU_IO_EN
        checkOutput("inT3", M_INPORTOUT | M_GRA | M_RIN, A_NONE, 3'd3, 1'b1); tick();
`else
        checkOutput("inAsNopT3", 32'h0, A_NONE, 3'd3, 1'b1); tick();
`endif

        $display("[TB] div aborted by Clear in T4");
        fetch(32'h7800_0000);
        checkOutput("divT3", M_GRA | M_ROUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        applyStimulus(32'h7800_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("divClearT4", 32'h0, A_NONE, 3'd0, 1'b1); tick();
        checkOutput("divClearHeld", 32'h0, A_NONE, 3'd0, 1'b1);
        applyStimulus(32'h7800_0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] mul then Stop");
        fetch(32'h8000_0000);
        checkOutput("mulT3", M_GRA | M_ROUT | M_YIN, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("mulT4", M_GRB | M_ROUT | M_ZIN, A_MUL, 3'd4, 1'b1); tick();
        applyStimulus(32'h8000_0000, 1'b0, 1'b1, 1'b0);
        checkOutput("mulT5", M_ZLOWOUT | M_LOIN, A_NONE, 3'd5, 1'b1); tick();
        checkOutput("mulT6", M_ZHIGHOUT | M_HIIN, A_NONE, 3'd6, 1'b1); tick();
        applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("haltHold", 32'h0, A_NONE, 3'd0, 1'b0);
            tick();
        end
        applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("haltClear", 32'h0, A_NONE, 3'd0, 1'b1);
        applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] halt opcode");
        fetch(32'hD800_0000);
        checkOutput("haltT3", 32'h0, A_NONE, 3'd3, 1'b1); tick();
        checkOutput("haltState", 32'h0, A_NONE, 3'd0, 1'b0); tick();
        checkOutput("haltStay", 32'h0, A_NONE, 3'd0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("restartT0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, A_NONE, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
